// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 data-memory stage: icodes, access classes, FSM states.
package y86_pkg;

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        NONE,
        RD,
        WR
    } acc_cls_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/y86_dmem_array.sv
// Single-port word storage with synchronous write and registered read.
module y86_dmem_array #(
    parameter int WORD_W = 64,
    parameter int DEPTH  = 128,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/y86_dmem_ctrl.sv
// Multi-cycle Y86 data-memory stage (IDLE -> BUSY -> DONE handshake).
// Optional DMEM_ALIGN_CHECK_EN: treat addr[2:0] != 0 as an address fault.
module y86_dmem_ctrl #(
    parameter int WORD_W  = 64,
    parameter int DEPTH   = 128,
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 64,
    localparam int VA_W   = (ADDR_W > WORD_W) ? ADDR_W : WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        icode,
    input  logic [VA_W-1:0]   valA,
    input  logic [WORD_W-1:0] valP,
    input  logic [ADDR_W-1:0] valE,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] valM,
    output logic              dmem_error
);

    import y86_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(1) << (IDX_W + 3);

    state_t            state;
    state_t            state_d;
    logic [3:0]        cnt;
    acc_cls_t          cls_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic              fault_q;
    logic [WORD_W-1:0] hold_q;
    logic [WORD_W-1:0] rdata;

    acc_cls_t          cls_in;
    logic [ADDR_W-1:0] addr_in;
    logic [WORD_W-1:0] wdata_in;
    logic              misalign;
    logic              fault_in;
    logic              accept;
    logic              fire;
    logic              we;
    logic              re;

    always_comb begin
        cls_in   = NONE;
        addr_in  = valE;
        wdata_in = valA[WORD_W-1:0];
        unique case (icode)
            IMRMOVQ: cls_in = RD;
            IRET, IPOPQ: begin
                cls_in  = RD;
                addr_in = valA[ADDR_W-1:0];
            end
            IRMMOVQ, IPUSHQ: cls_in = WR;
            ICALL: begin
                cls_in   = WR;
                wdata_in = valP;
            end
            default: cls_in = NONE;
        endcase
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = |addr_in[2:0];
`else
    assign misalign = 1'b0;
`endif

    assign fault_in = (cls_in != NONE)
                    && (({1'b0, addr_in} >= LIMIT) || misalign);

    assign req_ready = (state == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign fire      = (state == BUSY) && (cnt == 4'd0);
    // Gating with rst_n keeps a reset on the commit edge from writing.
    assign we        = fire && rst_n && (cls_q == WR) && !fault_q;
    assign re        = fire && (cls_q == RD) && !fault_q;

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (cnt == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cls_q   <= NONE;
            idx_q   <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                cnt     <= 4'(LATENCY - 1);
                cls_q   <= cls_in;
                idx_q   <= addr_in[IDX_W+2:3];
                wdata_q <= wdata_in;
                fault_q <= fault_in;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == DONE) begin
                hold_q <= valM;
            end
        end
    end

    assign rsp_valid  = rst_n && (state == DONE);
    assign dmem_error = rsp_valid && fault_q;

    always_comb begin
        valM = hold_q;
        if (!rst_n) begin
            valM = '0;
        end else if (rsp_valid) begin
            if (fault_q) begin
                valM = '0;
            end else if (cls_q == RD) begin
                valM = rdata;
            end
        end
    end

    y86_dmem_array #(
        .WORD_W(WORD_W),
        .DEPTH (DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .re   (re),
        .idx  (idx_q),
        .wdata(wdata_q),
        .rdata(rdata)
    );

endmodule

// File: doc/y86_dmem_ctrl.md
Name: y86_dmem_ctrl

Overview:
Parametrised, multi-cycle data-memory stage for the Y86 processor.
- Replaces the fixed 128-word, zero-latency data memory with a request/response block.
- Has configurable word width, depth and access latency, plus address checking that raises `dmem_error` for the status logic.
- Sits between execute (valE, valA, valP, icode) and write-back (valM); the stall logic uses `req_ready`/`rsp_valid`.

Parameters:
- WORD_W, 64, data width of valA/valP/valM and of each memory word.
- DEPTH, 128, number of words; must be a power of two and at least 2.
- LATENCY, 1, cycles spent in BUSY per access; range 1..15.
- ADDR_W, 64, width of the byte addresses valE/valA.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present; sampled with the fields below.
- req_ready  out  1  block can accept a request.
- icode  in  4  instruction code of the request.
- valA  in  ADDR_W/WORD_W  address for ret/popq; write data for rmmovq/pushq.
- valP  in  WORD_W  write data for call.
- valE  in  ADDR_W  address for mrmovq/rmmovq/call/pushq.
- rsp_valid  out  1  one-cycle pulse marking completion.
- valM  out  WORD_W  read data; valid while rsp_valid=1, held until the next completion.
- dmem_error  out  1  address fault on this completion; valid with rsp_valid.

Behaviour:
Reset and handshake
- Reset is synchronous, active-low, single clock (already decided).
- While rst_n=0: state=IDLE, req_ready=0, rsp_valid=0, valM=0, dmem_error=0. Array contents are not cleared.
- Request accepted on an edge where state=IDLE, rst_n=1, req_valid=1. req_ready = (state==IDLE) and rst_n.
- Accept captures icode, address, write data and a read/write/none class into request registers. Later changes on the inputs have no effect.

Access classes
- Read: mrmovq(5) from valE; ret(9) and popq(B) from valA.
- Write: rmmovq(4) valA→[valE]; call(8) valP→[valE]; pushq(A) valA→[valE].
- None: all other icodes. They still take the full handshake; no array access, valM unchanged, dmem_error=0.

Addressing
- Byte address; word index = addr[log2(DEPTH)+2 : 3].
- Fault if addr ≥ DEPTH*8 (compared at full ADDR_W), or if misaligned (see optional feature).
- On a fault: no write, valM forced to 0, dmem_error=1.

State machine (IDLE → BUSY → DONE → IDLE)
- IDLE→BUSY on accept; an internal counter loads LATENCY-1.
- BUSY holds while the counter ≠ 0, decrementing each cycle.
- BUSY→DONE when the counter = 0. On this edge the array write commits, or read data is registered into valM, along with dmem_error.
- DONE: rsp_valid=1 for exactly one cycle, then →IDLE.
- Accept-to-rsp_valid latency = LATENCY+1 cycles. Throughput is one request per LATENCY+2 cycles; no back-to-back accept in DONE.
- Array read is synchronous, taken from the captured index.

Boundary conditions
- Reset asserted in BUSY: request is dropped and no write commits.
- Reset asserted in DONE: the write has already committed; rsp_valid drops.
- Highest word (index DEPTH-1) is legal; address DEPTH*8 faults.
- Write followed by read of the same address returns the new data; no bypass is needed since accesses are serialised.
- req_valid while not ready is ignored; the requester must hold it.

Optional Feature:
DMEM_ALIGN_CHECK_EN
- Defined: addr[2:0]≠0 is a fault, handled like out-of-range (no write, valM=0, dmem_error=1).
- Undefined: addr[2:0] is ignored, and misaligned addresses access the containing word.

Decomposition:
Package y86_pkg holds:
- icode localparams IRMMOVQ=4, IMRMOVQ=5, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
- The access-class enum (NONE/RD/WR).
- The FSM state enum (IDLE/BUSY/DONE).

Sub-module y86_dmem_array:
- Single-port storage, DEPTH×WORD_W, synchronous write enable, registered read.
- Keeps the FSM, address decode and fault logic in the top level.

Test Plan:
1. Reset: rst_n=0 for 3 cycles → req_ready=0, rsp_valid=0, valM=0; first edge with rst_n=1 → req_ready=1.
2. rmmovq valE=0x10 valA=0xDEAD, then mrmovq valE=0x10, LATENCY=1 → rsp_valid two cycles after each accept; second response valM=0xDEAD, dmem_error=0.
3. call valE=0x3F8 valP=0x40, then ret valA=0x3F8 → valM=0x40. Then pushq valE=0x400 (DEPTH=128) → dmem_error=1; a following read of 0x3F8 still returns 0x40.
4. With DMEM_ALIGN_CHECK_EN: mrmovq valE=0x13 → dmem_error=1, valM=0. Without it: same request returns word 2, dmem_error=0.
5. LATENCY=4, rmmovq valE=0x8 valA=0x55, rst_n pulsed low at cycle 2 after accept → read of 0x8 returns the prior contents, not 0x55. Also check req_ready=0 throughout BUSY.
6. Non-memory icode 6 with req_valid held high continuously → rsp_valid every LATENCY+2 cycles, valM unchanged, dmem_error=0.
